// File: rtl/mmio_periph_pkg.sv
// mmio_pkg: register offsets, STAT bit positions and default base address shared by decode and read mux.
package mmio_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0100;
    localparam logic [3:0] OFF_TRIG = 4'h0;
    localparam logic [3:0] OFF_CYCLE = 4'h4;
    localparam logic [3:0] OFF_OUT = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;
    localparam int STAT_CNT_MSB = 2;
    localparam int STAT_FULL = 3;
    localparam int STAT_EMPTY = 4;
    localparam int STAT_OVF = 5;
endpackage

// File: rtl/mmio_periph_if.sv
// mmio_periph_if: CPU load/store port plus the output stream toward the consumer.
interface mmio_periph_if #(parameter int DATA_WIDTH = 32);
    logic [31:0] addr;
    logic we;
    logic [DATA_WIDTH-1:0] wd;
    logic hit;
    logic [DATA_WIDTH-1:0] rdata;
    logic out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic out_ready;
    modport master (output addr, we, wd, out_ready, input hit, rdata, out_valid, out_data);
    modport slave (input addr, we, wd, out_ready, output hit, rdata, out_valid, out_data);
endinterface

// File: rtl/mmio_periph_sync_fifo.sv
// sync_fifo: circular buffer with one extra pointer bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input logic clk,
    input logic rst_n,
    input logic i_push,
    input logic [DATA_WIDTH-1:0] i_din,
    output logic o_full,
    input logic i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic o_empty,
    output logic [AW:0] o_count
);
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic w_pop, w_push;
    assign w_pop = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign w_push = i_push && (!o_full || w_pop);
    assign o_empty = r_wr == r_rd;
    assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count = r_wr - r_rd;
    assign o_dout = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + (AW+1)'(w_push);
            r_rd <= r_rd + (AW+1)'(w_pop);
        end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: trigger flag, cycle counter, status and output FIFO mapped into a 16-byte window.
// Read data is combinational so a single-cycle core can mux it onto its load path.
module mmio_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    input logic i_trigger_in,
    mmio_periph_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic w_hit, w_wr, w_push, w_pop, w_full, w_empty, w_edge;
    logic [3:0] w_off;
    logic [AW:0] w_count;
    logic [DATA_WIDTH-1:0] w_dout, w_stat, r_cycle;
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_prev, r_pend, r_ovf;
    assign w_hit = bus.addr[31:4] == BASE_ADDR[31:4];
    assign w_off = bus.addr[3:0] & 4'hC;
    assign w_wr = bus.we && w_hit;
    assign w_push = w_wr && w_off == OFF_OUT;
    assign w_pop = bus.out_ready && !w_empty;
    assign w_edge = r_sync[SYNC_STAGES-1] && !r_prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_pend <= 1'b0;
            r_ovf <= 1'b0;
            r_cycle <= '0;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_trigger_in});
            r_prev <= r_sync[SYNC_STAGES-1];
            // set beats a simultaneous write-one-to-clear on both sticky flags
            r_pend <= w_edge || (r_pend && !(w_wr && w_off == OFF_TRIG && bus.wd[0]));
            r_ovf <= (w_push && w_full && !w_pop) || (r_ovf && !(w_wr && w_off == OFF_STAT && bus.wd[STAT_OVF]));
            r_cycle <= (w_wr && w_off == OFF_CYCLE) ? bus.wd : r_cycle + 1'b1;
        end
    always_comb begin
        w_stat = '0;
        w_stat[STAT_CNT_MSB:0] = 3'(w_count);
        w_stat[STAT_FULL] = w_full;
        w_stat[STAT_EMPTY] = w_empty;
        w_stat[STAT_OVF] = r_ovf;
    end
    assign bus.hit = w_hit;
    assign bus.rdata = !w_hit ? '0 :
                       w_off == OFF_TRIG ? DATA_WIDTH'(r_pend) :
                       w_off == OFF_CYCLE ? r_cycle :
                       w_off == OFF_STAT ? w_stat : '0;
    assign bus.out_valid = !w_empty;
    assign bus.out_data = w_dout;
    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .i_push(w_push),
        .i_din(bus.wd),
        .o_full(w_full),
        .i_pop(w_pop),
        .o_dout(w_dout),
        .o_empty(w_empty),
        .o_count(w_count)
    );
endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: directed scenarios plus random traffic against a queue-based reference model.
module tb_mmio_periph;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trig = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] m_cycle;
    logic m_pend, m_ovf;
    logic [31:0] m_q[$];
    logic [2:0] m_hist;
    mmio_periph_if #(.DATA_WIDTH(32)) bus();
    mmio_periph dut (.clk(clk), .rst_n(rst_n), .i_trigger_in(trig), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int sz = m_q.size();
        if (a < 32'h100 || a > 32'h10F) return 32'h0;
        case (a[3:2])
            2'd0: return {31'b0, m_pend};
            2'd1: return m_cycle;
            2'd2: return 32'h0;
            default: return {26'b0, m_ovf, sz == 0, sz == DEPTH, 3'(sz)};
        endcase
    endfunction

    task automatic model_reset();
        m_cycle = 0;
        m_pend = 0;
        m_ovf = 0;
        m_q.delete();
        m_hist = 0;
    endtask

    task automatic idle();
        bus.addr = 32'h0;
        bus.we = 1'b0;
        bus.wd = 32'h0;
        bus.out_ready = 1'b0;
    endtask

    // advance one clock, applying the register-map rules to the model first
    task automatic tick();
        bit hit = bus.addr >= 32'h100 && bus.addr <= 32'h10F;
        bit wr = hit && bus.we;
        bit [1:0] r = bus.addr[3:2];
        bit pop = m_q.size() > 0 && bus.out_ready;
        bit ovf_set = wr && r == 2 && m_q.size() == DEPTH && !pop;
        if (wr && r == 0 && bus.wd[0]) m_pend = 0;
        if (m_hist[1] && !m_hist[2]) m_pend = 1;
        m_hist = {m_hist[1:0], trig};
        m_cycle = (wr && r == 1) ? bus.wd : m_cycle + 1;
        if (wr && r == 3 && bus.wd[5]) m_ovf = 0;
        if (ovf_set) m_ovf = 1;
        if (pop) void'(m_q.pop_front());
        if (wr && r == 2 && !ovf_set) m_q.push_back(bus.wd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
        repeat (10) tick();
        bus.addr = 32'h104; #1;
        checks++; if (bus.rdata !== 32'd10) begin errors++; $display("FAIL idle_cycle: got %h expected %h", bus.rdata, 32'd10); end
        bus.addr = 32'h10C; #1;
        checks++; if (bus.rdata !== 32'h10) begin errors++; $display("FAIL reset_stat: got %h expected 10", bus.rdata); end
        bus.addr = 32'h0FC; #1;
        checks++; if (bus.hit !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL below_window: hit %b rdata %h expected 0/0", bus.hit, bus.rdata); end
        bus.addr = 32'h110; #1;
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL above_window: hit %b expected 0", bus.hit); end
        bus.addr = 32'h10F; #1;
        checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL top_of_window: hit %b expected 1", bus.hit); end
    endtask

    task automatic test_cycle();
        bus.addr = 32'h104; bus.we = 1; bus.wd = 32'hFFFF_FFFE;
        tick();
        bus.we = 0; #1;
        checks++; if (bus.rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load: got %h expected fffffffe", bus.rdata); end
        tick(); #1;
        checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_inc: got %h expected ffffffff", bus.rdata); end
        tick(); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h expected 0", bus.rdata); end
    endtask

    task automatic test_trigger();
        idle();
        bus.addr = 32'h100;
        trig = 1;
        tick(); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL trig_d1: got %h expected 0", bus.rdata); end
        tick(); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL trig_d2: got %h expected 0", bus.rdata); end
        tick(); #1;
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL trig_d3: got %h expected 1", bus.rdata); end
        bus.we = 1; bus.wd = 32'h1;
        tick();
        bus.we = 0; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL trig_w1c: got %h expected 0", bus.rdata); end
        tick(); #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL trig_held_once: got %h expected 0", bus.rdata); end
        trig = 0;
        repeat (3) tick();
        trig = 1;
        tick();
        tick();
        bus.we = 1; bus.wd = 32'h1;
        tick();
        bus.we = 0; #1;
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL trig_set_wins: got %h expected 1", bus.rdata); end
        bus.we = 1;
        tick();
        bus.we = 0; trig = 0; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL trig_clear: got %h expected 0", bus.rdata); end
    endtask

    task automatic test_fifo();
        logic [31:0] vals[5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.addr = 32'h108; bus.we = 1; bus.wd = vals[i];
            if (i == 0) begin
                #1;
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", bus.out_valid); end
            end
            tick();
            bus.we = 0; bus.addr = 32'h10C; #1;
            if (i == 3) begin checks++; if (bus.rdata !== 32'h0C) begin errors++; $display("FAIL stat_full: got %h expected 0c", bus.rdata); end end
            if (i == 4) begin checks++; if (bus.rdata !== 32'h2C) begin errors++; $display("FAIL stat_overflow: got %h expected 2c", bus.rdata); end end
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA) begin errors++; $display("FAIL head_hold: valid %b data %h expected 1/a", bus.out_valid, bus.out_data); end
        bus.addr = 32'h0; bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin errors++; $display("FAIL drain_%0d: valid %b data %h expected 1/%h", i, bus.out_valid, bus.out_data, vals[i]); end
            tick();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin errors++; $display("FAIL drained: valid %b data %h expected 0/0", bus.out_valid, bus.out_data); end
        bus.out_ready = 0; bus.addr = 32'h10C; bus.we = 1; bus.wd = 32'h20;
        tick();
        bus.we = 0; #1;
        checks++; if (bus.rdata !== 32'h10) begin errors++; $display("FAIL ovf_clear: got %h expected 10", bus.rdata); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp[4] = '{32'h2, 32'h3, 32'h4, 32'h55};
        idle();
        for (int i = 1; i <= 4; i++) begin
            bus.addr = 32'h108; bus.we = 1; bus.wd = i;
            tick();
        end
        bus.wd = 32'h55; bus.out_ready = 1; #1;
        checks++; if (bus.out_data !== 32'h1) begin errors++; $display("FAIL full_pop_head: got %h expected 1", bus.out_data); end
        tick();
        bus.we = 0; bus.out_ready = 0; bus.addr = 32'h10C; #1;
        checks++; if (bus.rdata !== 32'h0C) begin errors++; $display("FAIL full_pop_stat: got %h expected 0c", bus.rdata); end
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.out_data !== exp[i]) begin errors++; $display("FAIL full_pop_order_%0d: got %h expected %h", i, bus.out_data, exp[i]); end
            tick();
        end
        bus.out_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.addr = ($urandom_range(0, 7) == 0) ? 32'h0F0 + $urandom_range(0, 47) : 32'h100 + $urandom_range(0, 15);
            bus.we = $urandom_range(0, 2) == 0;
            bus.wd = $urandom;
            bus.out_ready = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 4) == 0) trig = ~trig;
            #1;
            checks++; if (bus.hit !== (bus.addr >= 32'h100 && bus.addr <= 32'h10F)) begin errors++; $display("FAIL rnd_hit %0d: got %b for addr %h", i, bus.hit, bus.addr); end
            checks++; if (bus.rdata !== exp_rd(bus.addr)) begin errors++; $display("FAIL rnd_rdata %0d: got %h expected %h", i, bus.rdata, exp_rd(bus.addr)); end
            checks++; if (bus.out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid %0d: got %b expected %b", i, bus.out_valid, m_q.size() > 0); end
            checks++; if (bus.out_data !== (m_q.size() > 0 ? m_q[0] : 32'h0)) begin errors++; $display("FAIL rnd_data %0d: got %h", i, bus.out_data); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        trig = 0;
        for (int i = 0; i < 4; i++) begin
            bus.addr = 32'h108; bus.we = 1; bus.wd = 32'h70 + i;
            tick();
        end
        bus.we = 0; bus.addr = 32'h0; bus.out_ready = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin errors++; $display("FAIL async_reset: valid %b data %h expected 0/0", bus.out_valid, bus.out_data); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        bus.out_ready = 0; bus.addr = 32'h10C; #1;
        checks++; if (bus.rdata !== 32'h10) begin errors++; $display("FAIL post_reset_stat: got %h expected 10", bus.rdata); end
        bus.addr = 32'h104; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL post_reset_cycle: got %h expected 0", bus.rdata); end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_trigger();
        test_fifo();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
- Memory-mapped peripheral that responds to the CPU's data-memory load/store port, alongside the data memory.
- Exposes four 32-bit registers: a synchronized external trigger flag, a free-running cycle counter, a status register, and an output FIFO.
- The FIFO drains to an external consumer (lights/display) through a valid/ready handshake.
- The CPU is the initiator and this block is the responder. Read data is combinational so the single-cycle core can select it on its load path.

Parameters:
- BASE_ADDR, 32'h0000_0100, word-aligned base of the 16-byte register window
- DATA_WIDTH, 32, register and bus width
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, ≥2
- SYNC_STAGES, 2, flip-flop stages on trigger_in

Ports:
- clk, input, 1, system clock; all state updates on rising edge
- rst, input, 1, asynchronous active-low reset
- addr, input, 32, CPU data address (ALU result)
- we, input, 1, CPU store strobe
- wd, input, 32, CPU store data
- hit, output, 1, addr falls in [BASE_ADDR, BASE_ADDR+15]; combinational
- rdata, output, 32, register read data; combinational; 0 when hit=0
- trigger_in, input, 1, asynchronous external trigger (push button)
- out_valid, output, 1, FIFO head is valid
- out_data, output, 32, FIFO head value
- out_ready, input, 1, consumer accepts head this cycle

Behaviour:
- Register map (offset from BASE_ADDR, word-aligned; addr[1:0] ignored):
  - 0x0 TRIG: bit0 = pending, sticky; write with wd[0]=1 clears it (W1C); other bits read 0.
  - 0x4 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0. A store loads wd; increments resume the following cycle.
  - 0x8 OUT: a store pushes wd into the FIFO; reads return 0.
  - 0xC STAT: [2:0] count, [3] full, [4] empty, [5] overflow (sticky, W1C via wd[5]=1); bits above 5 read 0.
- Stores act on the rising edge when we=1 and hit=1. Reads have no side effects.
- Reset (rst=0, asynchronous): pending=0, CYCLE=0, FIFO empty, overflow=0, sync flops=0. Outputs: out_valid=0, out_data=0 when empty.
- Trigger path:
  - trigger_in passes through SYNC_STAGES flops, then a rising-edge detect on the last stage.
  - An edge sets pending 3 cycles after the input rises (2 sync stages + edge register).
  - A held-high input sets pending only once.
  - If a W1C and an edge land in the same cycle, set wins and pending stays 1.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full/empty come from pointer MSB comparison.
  - Pop occurs when out_valid && out_ready. out_data = mem[rd_ptr]; out_valid = !empty.
  - Push to empty: out_valid rises the next cycle (no same-cycle bypass).
  - Push when full with no pop: data dropped, pointers unchanged, overflow set.
  - Push when full with a simultaneous pop: push accepted, count stays FIFO_DEPTH, overflow not set.
  - Push and pop together when neither full nor empty: count unchanged.
  - out_data holds stable while out_valid && !out_ready.
- Pointer wrap-around is modulo 2·FIFO_DEPTH; count = wr_ptr − rd_ptr.
- Reset asserted mid-transfer discards FIFO contents. out_valid falls asynchronously with reset.

Decomposition:
- Shared package mmio_pkg holds:
  - offset localparams OFF_TRIG=0x0, OFF_CYCLE=0x4, OFF_OUT=0x8, OFF_STAT=0xC
  - STAT bit-index constants
  - default BASE_ADDR
- Top-level system decode and the load-path mux use the same constants.
- One sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/din/full, pop/dout/empty, count, clk/rst).
- The synchronizer and edge detect stay inline.

Test Plan:
- Reset then idle 10 cycles → CYCLE reads 10, STAT reads 0x10 (empty), out_valid=0, hit=0 at addr 0x0FC.
- Store 0xFFFF_FFFE to 0x104 → next cycle reads 0xFFFF_FFFF; following cycle reads 0x0 (wrap).
- Pulse trigger_in high 5 cycles → TRIG reads 1 exactly 3 cycles after the rise, with one set only. Store 1 to 0x100 in the same cycle as a second edge → TRIG remains 1.
- out_ready=0, store 0xA,0xB,0xC,0xD,0xE to 0x108 → STAT=0x0C (count 4, full), then overflow set (0x2C). Then out_ready=1 → out_data sequence A,B,C,D; out_valid drops after D.
- FIFO full plus a simultaneous store of 0x55 and pop → count stays 4, no overflow; 0x55 emerges last.
- Assert rst low mid-drain with 3 entries queued → out_valid=0 immediately; after release STAT=0x10 and CYCLE=0.
